// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants used by the fetch stage and the main decoder.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0,x0,0 is the canonical bubble the decoder always recognises.
  localparam logic [31:0] NOP_INSTR = {25'b0, OP_ITYPE};

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, instruction memory port and IF/ID outputs.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            stall_f;
  logic            stall_d;
  logic            flush_d;
  logic            pc_src_e;
  logic [XLEN-1:0] pc_target_e;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic            valid_d;
  logic [31:0]     fetch_count;

  modport master (
    input  stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
    output imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_count
  );

  modport slave (
    output stall_f, stall_d, flush_d, pc_src_e, pc_target_e, imem_rdata,
    input  imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, fetch_count
  );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with flush-over-stall priority; reset and flush load the same value.
module if_id_reg #(
  parameter int           W         = 1,
  parameter logic [W-1:0] FLUSH_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (flush) begin
      data_d = FLUSH_VAL;
    end else if (!stall) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= FLUSH_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID register feeding decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_stage_if.master  fif
);

  localparam int IFID_W = 32 + XLEN + XLEN + 1;
  localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, {XLEN{1'b0}}, XLEN'(4), 1'b0};

  logic [XLEN-1:0]   pc_f_q;
  logic [XLEN-1:0]   pc_f_d;
  logic [XLEN-1:0]   pc_plus4_f;
  logic [XLEN-1:0]   target_aligned;
  logic [31:0]       fetch_count_q;
  logic [31:0]       fetch_count_d;
  logic              capture;
  logic [IFID_W-1:0] ifid_in;
  logic [IFID_W-1:0] ifid_out;

  assign pc_plus4_f     = pc_f_q + XLEN'(4);
  assign target_aligned = fif.pc_target_e & ~XLEN'(3);
  assign capture        = !fif.flush_d && !fif.stall_d;

  // A resolved branch must win over a load-use stall or it would be lost.
  always_comb begin
    pc_f_d = pc_plus4_f;
    if (fif.pc_src_e) begin
      pc_f_d = target_aligned;
    end else if (fif.stall_f) begin
      pc_f_d = pc_f_q;
    end
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (capture) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f_q        <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      pc_f_q        <= pc_f_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // ---- IF/ID boundary ----
  assign ifid_in = {fif.imem_rdata[31:0], pc_f_q, pc_plus4_f, 1'b1};

  if_id_reg #(
    .W         (IFID_W),
    .FLUSH_VAL (IFID_BUBBLE)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .flush (fif.flush_d),
    .stall (fif.stall_d),
    .d     (ifid_in),
    .q     (ifid_out)
  );

  assign fif.imem_addr   = pc_f_q;
  assign fif.instr_d     = ifid_out[IFID_W-1 -: 32];
  assign fif.pc_d        = ifid_out[2*XLEN : XLEN+1];
  assign fif.pc_plus4_d  = ifid_out[XLEN:1];
  assign fif.valid_d     = ifid_out[0];
  assign fif.fetch_count = fetch_count_q;

  if (XLEN > 32) begin : g_unused_hi
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^fif.imem_rdata[XLEN-1:32];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: a reference model pushes expected IF/ID state per edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(32)) fif ();
  fetch_stage_if #(.XLEN(32)) fif2 ();

  assign fif.imem_rdata  = 32'h13 + fif.imem_addr;
  assign fif2.imem_rdata = 32'h13 + fif2.imem_addr;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif.master)
  );

  fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .fif (fif2.master)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h4; m_valid = 1'b0; m_cnt = 32'h0;
    exp_q.delete();
  endtask

  // Drive one cycle of controls, predict the post-edge state, then compare after the edge.
  task automatic step(input logic sf, input logic sd, input logic fl, input logic ps,
                      input logic [31:0] tgt);
    exp_t e;
    exp_t got;
    fif.stall_f = sf; fif.stall_d = sd; fif.flush_d = fl;
    fif.pc_src_e = ps; fif.pc_target_e = tgt;
    if (fl) begin
      m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h4; m_valid = 1'b0;
    end else if (!sd) begin
      m_instr = 32'h13 + m_pc; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    if (ps)       m_pc = {tgt[31:2], 2'b00};
    else if (!sf) m_pc = m_pc + 32'd4;
    e = '{addr: m_pc, instr: m_instr, pc: m_pcd, pc4: m_pc4, valid: m_valid, cnt: m_cnt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk("imem_addr",   fif.imem_addr,   got.addr);
      chk("instr_d",     fif.instr_d,     got.instr);
      chk("pc_d",        fif.pc_d,        got.pc);
      chk("pc_plus4_d",  fif.pc_plus4_d,  got.pc4);
      chk("valid_d",     {31'd0, fif.valid_d}, {31'd0, got.valid});
      chk("fetch_count", fif.fetch_count, got.cnt);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"},  fif.imem_addr,   32'h0);
    chk({tag, "_instr"}, fif.instr_d,     NOP);
    chk({tag, "_pc"},    fif.pc_d,        32'h0);
    chk({tag, "_pc4"},   fif.pc_plus4_d,  32'h4);
    chk({tag, "_valid"}, {31'd0, fif.valid_d}, 32'd0);
    chk({tag, "_cnt"},   fif.fetch_count, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fif.stall_f = 0; fif.stall_d = 0; fif.flush_d = 0; fif.pc_src_e = 0; fif.pc_target_e = '0;
    fif2.stall_f = 0; fif2.stall_d = 0; fif2.flush_d = 0; fif2.pc_src_e = 0; fif2.pc_target_e = '0;
    model_reset();
    #12;
    chk_reset_vals("rst");
    chk("wrap_rst_addr", fif2.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    rst = 1'b0;

    // Free-run: addresses 0, 4 enter decode; PC reaches 8.
    step(0, 0, 0, 0, '0);
    chk("wrap_addr", fif2.imem_addr, 32'h0);
    chk("wrap_pc_d", fif2.pc_d, 32'hFFFF_FFFC);
    chk("wrap_pc4",  fif2.pc_plus4_d, 32'h0);
    step(0, 0, 0, 0, '0);
    chk("pc_at_8", fif.imem_addr, 32'h8);

    // Full freeze for two cycles.
    repeat (2) begin
      step(1, 1, 0, 0, '0);
      chk("frz_addr", fif.imem_addr, 32'h8);
      chk("frz_pc_d", fif.pc_d, 32'h4);
      chk("frz_cnt",  fif.fetch_count, 32'd2);
    end
    step(0, 0, 0, 0, '0);
    chk("run_cnt3", fif.fetch_count, 32'd3);
    chk("run_pc_d8", fif.pc_d, 32'h8);

    // Redirect with flush.
    step(0, 0, 1, 1, 32'h40);
    chk("redir_addr",  fif.imem_addr, 32'h40);
    chk("redir_instr", fif.instr_d, NOP);
    chk("redir_valid", {31'd0, fif.valid_d}, 32'd0);
    step(0, 0, 0, 0, '0);
    chk("redir_pc_d", fif.pc_d, 32'h40);
    chk("redir_instr2", fif.instr_d, 32'h53);

    // Redirect beats stall_f, target low bits dropped.
    step(1, 0, 0, 1, 32'h103);
    chk("align_addr", fif.imem_addr, 32'h100);

    // Flush beats stall_d.
    step(0, 1, 1, 0, '0);
    chk("fl_st_valid", {31'd0, fif.valid_d}, 32'd0);
    chk("fl_st_instr", fif.instr_d, NOP);

    // Mixed random traffic through the scoreboard.
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0),
           $urandom_range(0, 32'hFFFF));
    end

    // Async reset in the middle of a stall, no clock edge involved.
    fif.stall_f = 1; fif.stall_d = 1;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, '0);
    chk("post_rst_instr", fif.instr_d, 32'h13);
    step(0, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
